image_ocm_dualport: RTL and testbench
=====================================

IMAGE_OCM_DUALPORT -- requirements
Module: image_ocm_dualport

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width of both ports, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 75000: number of DATA_W-bit words.
REQ-003 SHALL have parameter ADDR_W, default 17: word-address width, with 2**ADDR_W >= DEPTH.
REQ-004 SHALL have parameter INIT_FILE, default "": hex image loaded at elaboration when non-empty.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port clken, input, 1: global clock enable.
REQ-008 SHALL have port s1_address, input, ADDR_W: port-1 word address.
REQ-009 SHALL have port s1_chipselect, input, 1: port-1 select.
REQ-010 SHALL have port s1_read, input, 1: port-1 read request.
REQ-011 SHALL have port s1_write, input, 1: port-1 write request.
REQ-012 SHALL have port s1_byteenable, input, DATA_W/8: port-1 byte lanes.
REQ-013 SHALL have port s1_writedata, input, DATA_W: port-1 write data.
REQ-014 SHALL have port s1_readdata, output, DATA_W: port-1 read data.
REQ-015 SHALL have port s1_readdatavalid, output, 1: port-1 read-data qualifier.
REQ-016 SHALL have port s1_oor, output, 1: sticky port-1 out-of-range flag.
REQ-017 SHALL have a port-2 set s2_address through s2_oor, identical in direction, width and meaning to the port-1 set.

Function
REQ-018 SHALL accept one access per port per clk edge where clken=1 and chipselect=1; never stall (no waitrequest).
REQ-019 SHALL write only the lanes whose byteenable bit is 1 when write=1.
REQ-020 SHALL give read latency 1: readdatavalid=1 and readdata valid on the edge after acceptance, both for exactly 1 cycle per read.
REQ-021 SHALL return old contents on a same-port or cross-port read of an address written in the same cycle.
REQ-022 SHALL, on simultaneous s1/s2 writes to one address, take s1 data on s1-enabled lanes and s2 data on all other s2-enabled lanes.
REQ-023 SHALL ignore read and write together asserted: treat as write only, with no readdatavalid.
REQ-024 SHALL, for address >= DEPTH, suppress the write, return readdata=0 with readdatavalid=1 on reads, and set the port's oor flag until reset.
REQ-025 SHALL, while clken=0, accept nothing, leave memory unchanged, and hold readdata, readdatavalid and the pipeline registers.
REQ-026 SHALL drive readdata to 0 whenever readdatavalid=0.

Reset
REQ-027 SHALL, on reset_n=0, immediately clear readdatavalid, readdata, the oor flags and all pipeline registers to 0.
REQ-028 SHALL discard any in-flight read when reset asserts mid-access; memory contents are not cleared.
REQ-029 SHALL accept accesses on the first clk edge after reset_n rises.

Configuration
REQ-030 SHALL, with macro IMAGE_OCM_OUTREG_EN defined, add an output register stage: read latency 2, with readdatavalid delayed identically.
REQ-031 SHALL, without IMAGE_OCM_OUTREG_EN, have read latency 1 and no extra stage; all other requirements hold in both builds.

Structure
REQ-032 SHALL place the default widths and depth, the latency constants (1 and 2), and the port-request struct typedef (address, read, write, byteenable, writedata) in package image_ocm_pkg.
REQ-033 SHALL implement per-port request decode, oor tracking and the read pipeline in one sub-module, image_ocm_port, instantiated twice around a shared memory array.

Verification
REQ-034 SHALL cover: s1 writes 0xDEADBEEF to 0x10 with be=0xF, then s2 reads 0x10 -> s2_readdatavalid high 1 cycle later (2 with OUTREG), readdata=0xDEADBEEF.
REQ-035 SHALL cover: s1 be=0x3 data 0x11112222 and s2 be=0xF data 0xAAAABBBB, same cycle to address 5 -> read of 5 returns 0xAAAA2222.
REQ-036 SHALL cover: s1 reads address 75000 -> readdata=0, readdatavalid=1, s1_oor=1 and stays high; s2_oor stays 0.
REQ-037 SHALL cover: read issued, then clken=0 for 3 cycles -> readdatavalid held, no new data; resumes correctly after clken=1.
REQ-038 SHALL cover: reset_n pulsed low the cycle after a read -> readdatavalid=0 immediately; previously written memory data is still readable after reset.
REQ-039 SHALL cover: same-cycle s1 write 0x5 and s2 read of address 7, pre-loaded with 0x9 -> s2 gets 0x9; next read gets 0x5.

Source files
------------

// File: rtl/image_ocm_pkg.sv
// rtl/image_ocm_pkg.sv - shared defaults, read latencies and port-request record for the dual-port OCM
package image_ocm_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 75000;
    localparam int ADDR_W_DEF = 17;
    localparam int LAT_BASE   = 1;
    localparam int LAT_OUTREG = 2;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]   address;
        logic                    read;
        logic                    write;
        logic [DATA_W_DEF/8-1:0] byteenable;
        logic [DATA_W_DEF-1:0]   writedata;
    } port_req_t;
endpackage

// File: rtl/image_ocm_if.sv
// rtl/image_ocm_if.sv - one OCM access port: request from the master, read data and oor flag back
interface image_ocm_if import image_ocm_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                oor;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, oor
    );
    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, oor
    );
endinterface

// File: rtl/image_ocm_port.sv
// rtl/image_ocm_port.sv - per-port decode, sticky oor flag and read pipeline
// IMAGE_OCM_OUTREG_EN adds a second read stage (latency 2).
module image_ocm_port import image_ocm_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    image_ocm_if.slave          bus,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W/8-1:0] o_mem_we,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic [DATA_W-1:0]   i_mem_q
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic              w_acc;
    logic              w_oor;
    logic              w_rd;
    logic              w_wr;
    logic              r_vld1;
    logic              r_oor1;
    logic              r_oor_flag;
    logic [DATA_W-1:0] w_d1;

    assign w_acc = clken & bus.chipselect;
    assign w_oor = {1'b0, bus.address} >= DEPTH_L;
    assign w_wr  = w_acc & bus.write;
    assign w_rd  = w_acc & bus.read & ~bus.write;

    // Out-of-range addresses are clamped so the array is never indexed past its end
    assign o_mem_addr  = w_oor ? '0 : bus.address;
    assign o_mem_we    = (w_wr && !w_oor) ? bus.byteenable : '0;
    assign o_mem_wdata = bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld1     <= 1'b0;
            r_oor1     <= 1'b0;
            r_oor_flag <= 1'b0;
        end else if (clken) begin
            r_vld1 <= w_rd;
            r_oor1 <= w_rd & w_oor;
            if (w_acc && (bus.read || bus.write) && w_oor)
                r_oor_flag <= 1'b1;
        end
    end

    assign w_d1    = (r_vld1 && !r_oor1) ? i_mem_q : '0;
    assign bus.oor = r_oor_flag;

`ifdef IMAGE_OCM_OUTREG_EN
    logic              r_vld2;
    logic [DATA_W-1:0] r_d2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld2 <= 1'b0;
            r_d2   <= '0;
        end else if (clken) begin
            r_vld2 <= r_vld1;
            r_d2   <= w_d1;
        end
    end

    assign bus.readdatavalid = r_vld2;
    assign bus.readdata      = r_d2;
`else
    assign bus.readdatavalid = r_vld1;
    assign bus.readdata      = w_d1;
`endif
endmodule

// File: rtl/image_ocm_dualport.sv
// rtl/image_ocm_dualport.sv - true dual-port on-chip memory with byte lanes and oor detection
// Optional output register stage selected by IMAGE_OCM_OUTREG_EN.
module image_ocm_dualport import image_ocm_pkg::*; #(
    parameter int    DATA_W    = DATA_W_DEF,
    parameter int    DEPTH     = DEPTH_DEF,
    parameter int    ADDR_W    = ADDR_W_DEF,
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_oor,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_oor
);
    image_ocm_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) w_s1_if ();
    image_ocm_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) w_s2_if ();

    assign w_s1_if.address    = s1_address;
    assign w_s1_if.chipselect = s1_chipselect;
    assign w_s1_if.read       = s1_read;
    assign w_s1_if.write      = s1_write;
    assign w_s1_if.byteenable = s1_byteenable;
    assign w_s1_if.writedata  = s1_writedata;
    assign s1_readdata        = w_s1_if.readdata;
    assign s1_readdatavalid   = w_s1_if.readdatavalid;
    assign s1_oor             = w_s1_if.oor;

    assign w_s2_if.address    = s2_address;
    assign w_s2_if.chipselect = s2_chipselect;
    assign w_s2_if.read       = s2_read;
    assign w_s2_if.write      = s2_write;
    assign w_s2_if.byteenable = s2_byteenable;
    assign w_s2_if.writedata  = s2_writedata;
    assign s2_readdata        = w_s2_if.readdata;
    assign s2_readdatavalid   = w_s2_if.readdatavalid;
    assign s2_oor             = w_s2_if.oor;

    logic [ADDR_W-1:0]   w_addr1, w_addr2;
    logic [DATA_W/8-1:0] w_we1, w_we2;
    logic [DATA_W-1:0]   w_wd1, w_wd2;
    logic [DATA_W-1:0]   r_q1, r_q2;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    image_ocm_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port1 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .bus(w_s1_if),
        .o_mem_addr(w_addr1), .o_mem_we(w_we1), .o_mem_wdata(w_wd1), .i_mem_q(r_q1)
    );

    image_ocm_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port2 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .bus(w_s2_if),
        .o_mem_addr(w_addr2), .o_mem_we(w_we2), .o_mem_wdata(w_wd2), .i_mem_q(r_q2)
    );

    // Port 1 lane writes are issued last so they win any same-address, same-lane collision;
    // reads sample the array before this edge's writes land (read-old-data).
    always_ff @(posedge clk) begin
        if (clken) begin
            for (int b = 0; b < DATA_W/8; b++)
                if (w_we2[b]) r_mem[w_addr2][8*b +: 8] <= w_wd2[8*b +: 8];
            for (int b = 0; b < DATA_W/8; b++)
                if (w_we1[b]) r_mem[w_addr1][8*b +: 8] <= w_wd1[8*b +: 8];
            r_q1 <= r_mem[w_addr1];
            r_q2 <= r_mem[w_addr2];
        end
    end
endmodule

// File: tb/tb_image_ocm_dualport.sv
// tb/tb_image_ocm_dualport.sv - table, directed and randomized checks of image_ocm_dualport
module tb_image_ocm_dualport;
    import image_ocm_pkg::*;

    localparam int DW    = DATA_W_DEF;
    localparam int AW    = ADDR_W_DEF;
    localparam int DEPTH = DEPTH_DEF;
`ifdef IMAGE_OCM_OUTREG_EN
    localparam int LAT = LAT_OUTREG;
`else
    localparam int LAT = LAT_BASE;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic clken;
    always #5 clk = ~clk;

    image_ocm_if #(.DATA_W(DW), .ADDR_W(AW)) s1_bus ();
    image_ocm_if #(.DATA_W(DW), .ADDR_W(AW)) s2_bus ();

    image_ocm_dualport #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_bus.address), .s1_chipselect(s1_bus.chipselect),
        .s1_read(s1_bus.read), .s1_write(s1_bus.write),
        .s1_byteenable(s1_bus.byteenable), .s1_writedata(s1_bus.writedata),
        .s1_readdata(s1_bus.readdata), .s1_readdatavalid(s1_bus.readdatavalid),
        .s1_oor(s1_bus.oor),
        .s2_address(s2_bus.address), .s2_chipselect(s2_bus.chipselect),
        .s2_read(s2_bus.read), .s2_write(s2_bus.write),
        .s2_byteenable(s2_bus.byteenable), .s2_writedata(s2_bus.writedata),
        .s2_readdata(s2_bus.readdata), .s2_readdatavalid(s2_bus.readdatavalid),
        .s2_oor(s2_bus.oor)
    );

    typedef struct packed { logic v; logic [DW-1:0] d; } rsp_t;
    typedef struct {
        port_req_t r1; logic c1; port_req_t r2; logic c2;
        logic v1; logic [DW-1:0] d1; logic v2; logic [DW-1:0] d2;
    } vec_t;

    rsp_t          pipe1[$];
    rsp_t          pipe2[$];
    logic [DW-1:0] mem_m [int];
    logic          oor1_m, oor2_m;
    int            total = 0;
    int            bad   = 0;
    port_req_t     idle_r;
    vec_t          tbl[12];

    function automatic port_req_t rq(int a, logic rd, logic wr, logic [3:0] be, logic [31:0] wd);
        port_req_t r;
        r.address = AW'(a); r.read = rd; r.write = wr; r.byteenable = be; r.writedata = wd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: a word store plus a delay line of LAT read results per port
    function automatic rsp_t model_read(port_req_t r, logic cs);
        rsp_t x = '0;
        if (cs && r.read && !r.write) begin
            x.v = 1'b1;
            x.d = (int'(r.address) < DEPTH) ? mem_m[int'(r.address)] : '0;
        end
        return x;
    endfunction

    task automatic model_write(input port_req_t r, input logic cs);
        logic [DW-1:0] w;
        if (!(cs && r.write) || int'(r.address) >= DEPTH) return;
        w = mem_m.exists(int'(r.address)) ? mem_m[int'(r.address)] : '0;
        for (int b = 0; b < DW/8; b++)
            if (r.byteenable[b]) w[8*b +: 8] = r.writedata[8*b +: 8];
        mem_m[int'(r.address)] = w;
    endtask

    task automatic model_reset();
        pipe1 = {};
        pipe2 = {};
        for (int i = 0; i < LAT; i++) begin
            pipe1.push_back('0);
            pipe2.push_back('0);
        end
        oor1_m = 1'b0;
        oor2_m = 1'b0;
    endtask

    task automatic model_step(input port_req_t r1, input logic c1, input port_req_t r2,
                              input logic c2, input logic ce);
        rsp_t x1, x2;
        if (!ce) return;
        x1 = model_read(r1, c1);
        x2 = model_read(r2, c2);
        if (c1 && (r1.read || r1.write) && int'(r1.address) >= DEPTH) oor1_m = 1'b1;
        if (c2 && (r2.read || r2.write) && int'(r2.address) >= DEPTH) oor2_m = 1'b1;
        model_write(r2, c2);
        model_write(r1, c1);
        pipe1.push_back(x1);
        pipe2.push_back(x2);
        if (pipe1.size() > LAT) void'(pipe1.pop_front());
        if (pipe2.size() > LAT) void'(pipe2.pop_front());
    endtask

    task automatic step(input port_req_t r1, input logic c1, input port_req_t r2,
                        input logic c2, input logic ce);
        s1_bus.address = r1.address; s1_bus.chipselect = c1; s1_bus.read = r1.read;
        s1_bus.write = r1.write; s1_bus.byteenable = r1.byteenable; s1_bus.writedata = r1.writedata;
        s2_bus.address = r2.address; s2_bus.chipselect = c2; s2_bus.read = r2.read;
        s2_bus.write = r2.write; s2_bus.byteenable = r2.byteenable; s2_bus.writedata = r2.writedata;
        clken = ce;
        model_step(r1, c1, r2, c2, ce);
        @(posedge clk);
        #1;
        chk("m_s1_valid", s1_bus.readdatavalid, pipe1[0].v);
        chk("m_s1_data",  s1_bus.readdata,      pipe1[0].d);
        chk("m_s1_oor",   s1_bus.oor,           oor1_m);
        chk("m_s2_valid", s2_bus.readdatavalid, pipe2[0].v);
        chk("m_s2_data",  s2_bus.readdata,      pipe2[0].d);
        chk("m_s2_oor",   s2_bus.oor,           oor2_m);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) step(idle_r, 1'b0, idle_r, 1'b0, 1'b1);
    endtask

    function automatic port_req_t rnd_req();
        int sel = $urandom_range(0, 19);
        int a   = (sel < 16) ? sel : (sel == 16) ? DEPTH - 1 : (sel == 17) ? DEPTH :
                  (sel == 18) ? (1 << AW) - 1 : $urandom_range(0, 15);
        return rq(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  4'($urandom), $urandom);
    endfunction

    initial begin
        idle_r = rq(0, 1'b0, 1'b0, 4'h0, 32'h0);
        s1_bus.address = '0; s1_bus.chipselect = 1'b0; s1_bus.read = 1'b0; s1_bus.write = 1'b0;
        s1_bus.byteenable = '0; s1_bus.writedata = '0;
        s2_bus.address = '0; s2_bus.chipselect = 1'b0; s2_bus.read = 1'b0; s2_bus.write = 1'b0;
        s2_bus.byteenable = '0; s2_bus.writedata = '0;
        clken   = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_s1_valid", s1_bus.readdatavalid, 1'b0);
        chk("reset_s1_data",  s1_bus.readdata,      '0);
        chk("reset_s1_oor",   s1_bus.oor,           1'b0);
        chk("reset_s2_valid", s2_bus.readdatavalid, 1'b0);
        chk("reset_s2_oor",   s2_bus.oor,           1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();

        for (int a = 0; a < 16; a++)
            step(rq(a, 1'b0, 1'b1, 4'hF, $urandom), 1'b1, idle_r, 1'b0, 1'b1);

        tbl[0]  = '{rq(16, 0, 1, 4'hF, 32'hDEADBEEF), 1, idle_r, 0, 0, 0, 0, 0};
        tbl[1]  = '{idle_r, 0, rq(16, 1, 0, 4'h0, 0), 1, 0, 0, 1, 32'hDEADBEEF};
        tbl[2]  = '{rq(5, 0, 1, 4'h3, 32'h11112222), 1, rq(5, 0, 1, 4'hF, 32'hAAAABBBB), 1, 0, 0, 0, 0};
        tbl[3]  = '{rq(5, 1, 0, 4'h0, 0), 1, idle_r, 0, 1, 32'hAAAA2222, 0, 0};
        tbl[4]  = '{rq(7, 0, 1, 4'hF, 32'h9), 1, idle_r, 0, 0, 0, 0, 0};
        tbl[5]  = '{rq(7, 0, 1, 4'hF, 32'h5), 1, rq(7, 1, 0, 4'h0, 0), 1, 0, 0, 1, 32'h9};
        tbl[6]  = '{idle_r, 0, rq(7, 1, 0, 4'h0, 0), 1, 0, 0, 1, 32'h5};
        tbl[7]  = '{rq(8, 1, 1, 4'hF, 32'h12345678), 1, idle_r, 0, 0, 0, 0, 0};
        tbl[8]  = '{idle_r, 0, rq(8, 1, 0, 4'h0, 0), 1, 0, 0, 1, 32'h12345678};
        tbl[9]  = '{rq(9, 0, 1, 4'hF, 32'h11223344), 1, idle_r, 0, 0, 0, 0, 0};
        tbl[10] = '{idle_r, 0, rq(9, 0, 1, 4'h6, 32'hAABBCCDD), 1, 0, 0, 0, 0};
        tbl[11] = '{rq(9, 1, 0, 4'h0, 0), 1, rq(9, 1, 0, 4'h0, 0), 1, 1, 32'h11BBCC44, 1, 32'h11BBCC44};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r1, tbl[i].c1, tbl[i].r2, tbl[i].c2, 1'b1);
            idle_cycles(LAT - 1);
            chk($sformatf("vec%0d_s1_valid", i), s1_bus.readdatavalid, tbl[i].v1);
            chk($sformatf("vec%0d_s1_data", i),  s1_bus.readdata,      tbl[i].d1);
            chk($sformatf("vec%0d_s2_valid", i), s2_bus.readdatavalid, tbl[i].v2);
            chk($sformatf("vec%0d_s2_data", i),  s2_bus.readdata,      tbl[i].d2);
        end

        // Last in-range word, then out-of-range read and write on port 1 only
        step(rq(DEPTH - 1, 0, 1, 4'hF, 32'hCAFEF00D), 1'b1, idle_r, 1'b0, 1'b1);
        step(rq(DEPTH - 1, 1, 0, 4'h0, 0), 1'b1, idle_r, 1'b0, 1'b1);
        idle_cycles(LAT - 1);
        chk("last_word_data", s1_bus.readdata, 32'hCAFEF00D);
        chk("last_word_oor",  s1_bus.oor,      1'b0);
        step(rq(DEPTH, 1, 0, 4'h0, 0), 1'b1, idle_r, 1'b0, 1'b1);
        idle_cycles(LAT - 1);
        chk("oor_read_valid", s1_bus.readdatavalid, 1'b1);
        chk("oor_read_data",  s1_bus.readdata,      '0);
        chk("oor_s1_flag",    s1_bus.oor,           1'b1);
        step(rq(DEPTH, 0, 1, 4'hF, 32'hFFFFFFFF), 1'b1, idle_r, 1'b0, 1'b1);
        idle_cycles(3);
        chk("oor_s1_sticky", s1_bus.oor, 1'b1);
        chk("oor_s2_clear",  s2_bus.oor, 1'b0);
        step(idle_r, 1'b0, rq(0, 1, 0, 4'h0, 0), 1'b1, 1'b1);
        idle_cycles(LAT - 1);

        // Clock-enable low for three cycles with a pending read and ignored write traffic
        step(idle_r, 1'b0, rq(16, 1, 0, 4'h0, 0), 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(rq(16, 0, 1, 4'hF, 32'h0), 1'b1, rq(16, 1, 0, 4'h0, 0), 1'b1, 1'b0);
            chk("hold_valid", s2_bus.readdatavalid, (LAT == 1));
            chk("hold_data",  s2_bus.readdata,      (LAT == 1) ? 32'hDEADBEEF : 32'h0);
        end
        step(idle_r, 1'b0, idle_r, 1'b0, 1'b1);
        step(idle_r, 1'b0, rq(16, 1, 0, 4'h0, 0), 1'b1, 1'b1);
        idle_cycles(LAT - 1);
        chk("resume_valid", s2_bus.readdatavalid, 1'b1);
        chk("resume_data",  s2_bus.readdata,      32'hDEADBEEF);

        // Reset pulsed right after a read is accepted
        step(rq(16, 1, 0, 4'h0, 0), 1'b1, idle_r, 1'b0, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_s1_valid", s1_bus.readdatavalid, 1'b0);
        chk("rst_s1_data",  s1_bus.readdata,      '0);
        chk("rst_s1_oor",   s1_bus.oor,           1'b0);
        chk("rst_s2_valid", s2_bus.readdatavalid, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        step(idle_r, 1'b0, rq(16, 1, 0, 4'h0, 0), 1'b1, 1'b1);
        idle_cycles(LAT - 1);
        chk("post_rst_valid", s2_bus.readdatavalid, 1'b1);
        chk("post_rst_data",  s2_bus.readdata,      32'hDEADBEEF);

        for (int n = 0; n < 400; n++)
            step(rnd_req(), ($urandom_range(0, 3) != 0), rnd_req(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
